// File: rtl/apb_wdog_ctrl_pkg.sv
// Shared definitions for the APB watchdog sequencer: register map, request ops,
// FSM states and the per-step descriptor produced by the step ROM.
package apb_wdog_ctrl_pkg;

   localparam int unsigned AW = 10;

   // Word addresses (byte offset >> 2)
   localparam logic [AW-1:0] REG_LOAD    = 10'h000;
   localparam logic [AW-1:0] REG_VALUE   = 10'h001;
   localparam logic [AW-1:0] REG_CONTROL = 10'h002;
   localparam logic [AW-1:0] REG_INTCLR  = 10'h003;
   localparam logic [AW-1:0] REG_LOCK    = 10'h300;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_CFG  = 3'd1,
      OP_KICK = 3'd2,
      OP_STOP = 3'd3,
      OP_RD   = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      WD_ZERO   = 3'd0,
      WD_KEY    = 3'd1,
      WD_RELOCK = 3'd2,
      WD_LOAD   = 3'd3,
      WD_CTRL   = 3'd4,
      WD_ONE    = 3'd5
   } wsel_e;

   typedef struct packed {
      logic [AW-1:0] paddr;
      logic          pwrite;
      wsel_e         wsel;
      logic          last;
   } step_t;

   function automatic step_t mk_step(input logic [AW-1:0] a, input logic w,
                                     input wsel_e s, input logic l);
      step_t e;
      e.paddr  = a;
      e.pwrite = w;
      e.wsel   = s;
      e.last   = l;
      return e;
   endfunction

endpackage

// File: rtl/apb_wdog_step_rom.sv
// Combinational table mapping (op, step) to the APB transfer to issue and
// whether it is the final transfer of the sequence.
module apb_wdog_step_rom
   import apb_wdog_ctrl_pkg::*;
(
   input  op_e        op,
   input  logic [1:0] step,
   output step_t      ent
);

   always_comb begin
      ent = mk_step(REG_LOAD, 1'b0, WD_ZERO, 1'b1);
      case (op)
         OP_CFG: begin
            case (step)
               2'd0:    ent = mk_step(REG_LOCK,    1'b1, WD_KEY,    1'b0);
               2'd1:    ent = mk_step(REG_LOAD,    1'b1, WD_LOAD,   1'b0);
               2'd2:    ent = mk_step(REG_CONTROL, 1'b1, WD_CTRL,   1'b0);
               default: ent = mk_step(REG_LOCK,    1'b1, WD_RELOCK, 1'b1);
            endcase
         end
         OP_KICK: begin
            case (step)
               2'd0:    ent = mk_step(REG_LOCK,   1'b1, WD_KEY,    1'b0);
               2'd1:    ent = mk_step(REG_INTCLR, 1'b1, WD_ONE,    1'b0);
               default: ent = mk_step(REG_LOCK,   1'b1, WD_RELOCK, 1'b1);
            endcase
         end
         OP_STOP: begin
            case (step)
               2'd0:    ent = mk_step(REG_LOCK,    1'b1, WD_KEY,    1'b0);
               2'd1:    ent = mk_step(REG_CONTROL, 1'b1, WD_ZERO,   1'b0);
               default: ent = mk_step(REG_LOCK,    1'b1, WD_RELOCK, 1'b1);
            endcase
         end
         OP_RD:   ent = mk_step(REG_VALUE, 1'b0, WD_ZERO, 1'b1);
         default: ;
      endcase
   end

endmodule

// File: rtl/apb_wdog_ctrl.sv
// APB2 master that turns single-cycle watchdog requests into lock/unlock
// bracketed register write sequences (or a VALUE read), one at a time.
module apb_wdog_ctrl
   import apb_wdog_ctrl_pkg::*;
#(
   parameter logic [31:0] UNLOCK_KEY = 32'h1ACC_E551,
   parameter logic [31:0] LOCK_VALUE = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_req,
   input  logic [31:0]   cfg_load,
   input  logic          cfg_inten,
   input  logic          cfg_resen,
   input  logic          kick_req,
   input  logic          stop_req,
   input  logic          rd_req,
   output logic          psel,
   output logic          penable,
   output logic          pwrite,
   output logic [AW-1:0] paddr,
   output logic [31:0]   pwdata,
   input  logic [31:0]   prdata,
   output logic          busy,
   output logic          done,
   output logic [31:0]   rd_value,
   output logic          rd_valid
);

   state_e      state, state_nx;
   op_e         op, op_nx;
   logic [1:0]  step, step_nx;
   logic        pend_cfg, pend_kick, pend_stop, pend_rd;
   logic        eff_cfg, eff_kick, eff_stop, eff_rd;
   logic        acc_cfg, acc_kick, acc_stop, acc_rd;
   logic [31:0] sh_load;
   logic [1:0]  sh_ctrl;
   logic [31:0] wdata;
   logic        xfer;
   step_t       ent;

   // Same-cycle requests are visible to arbitration so an idle block starts next cycle
   assign eff_cfg  = pend_cfg  | cfg_req;
   assign eff_kick = pend_kick | kick_req;
   assign eff_stop = pend_stop | stop_req;
   assign eff_rd   = pend_rd   | rd_req;

   apb_wdog_step_rom u_rom (
      .op   (op),
      .step (step),
      .ent  (ent)
   );

   always_comb begin
      state_nx = state;
      op_nx    = op;
      step_nx  = step;
      acc_cfg  = 1'b0;
      acc_kick = 1'b0;
      acc_stop = 1'b0;
      acc_rd   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            // DONE doubles as the mandatory idle cycle between sequences
            state_nx = ST_IDLE;
            op_nx    = OP_NONE;
            step_nx  = 2'd0;
            if (eff_stop) begin
               acc_stop = 1'b1;
               op_nx    = OP_STOP;
            end else if (eff_cfg) begin
               acc_cfg = 1'b1;
               op_nx   = OP_CFG;
            end else if (eff_kick) begin
               acc_kick = 1'b1;
               op_nx    = OP_KICK;
            end else if (eff_rd) begin
               acc_rd = 1'b1;
               op_nx  = OP_RD;
            end
            if (op_nx != OP_NONE) state_nx = ST_SETUP;
         end
         ST_SETUP: state_nx = ST_ACCESS;
         ST_ACCESS: begin
            if (ent.last) begin
               state_nx = ST_DONE;
            end else begin
               state_nx = ST_SETUP;
               step_nx  = step + 2'd1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         op        <= OP_NONE;
         step      <= 2'd0;
         pend_cfg  <= 1'b0;
         pend_kick <= 1'b0;
         pend_stop <= 1'b0;
         pend_rd   <= 1'b0;
         sh_load   <= 32'h0;
         sh_ctrl   <= 2'b00;
         rd_value  <= 32'h0;
      end else begin
         state     <= state_nx;
         op        <= op_nx;
         step      <= step_nx;
         pend_stop <= eff_stop & ~acc_stop;
         pend_cfg  <= eff_cfg  & ~acc_cfg;
         pend_kick <= eff_kick & ~acc_kick & ~acc_stop;
         pend_rd   <= eff_rd   & ~acc_rd;
         if (cfg_req) begin
            sh_load <= cfg_load;
            sh_ctrl <= {cfg_resen, cfg_inten};
         end
         if (state == ST_ACCESS && op == OP_RD) rd_value <= prdata;
      end
   end

   always_comb begin
      case (ent.wsel)
         WD_KEY:    wdata = UNLOCK_KEY;
         WD_RELOCK: wdata = LOCK_VALUE;
         WD_LOAD:   wdata = sh_load;
         WD_CTRL:   wdata = {30'b0, sh_ctrl};
         WD_ONE:    wdata = 32'h1;
         default:   wdata = 32'h0;
      endcase
   end

   assign xfer     = (state == ST_SETUP) || (state == ST_ACCESS);
   assign psel     = xfer;
   assign penable  = (state == ST_ACCESS);
   assign pwrite   = xfer & ent.pwrite;
   assign paddr    = xfer ? ent.paddr : '0;
   assign pwdata   = (xfer && ent.pwrite) ? wdata : 32'h0;
   assign busy     = xfer;
   assign done     = (state == ST_DONE);
   assign rd_valid = (state == ST_DONE) && (op == OP_RD);

endmodule

// File: tb/tb_apb_wdog_ctrl.sv
// Directed bench for apb_wdog_ctrl with a behavioural watchdog slave, an APB
// transfer log and a protocol monitor.
module tb_apb_wdog_ctrl;

   localparam logic [31:0] KEY = 32'h1ACC_E551;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_req, cfg_inten, cfg_resen, kick_req, stop_req, rd_req;
   logic [31:0] cfg_load;
   logic        psel, penable, pwrite, busy, done, rd_valid;
   logic [9:0]  paddr;
   logic [31:0] pwdata, prdata, rd_value;

   always #5 clk = ~clk;

   apb_wdog_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_req   (cfg_req),
      .cfg_load  (cfg_load),
      .cfg_inten (cfg_inten),
      .cfg_resen (cfg_resen),
      .kick_req  (kick_req),
      .stop_req  (stop_req),
      .rd_req    (rd_req),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .busy      (busy),
      .done      (done),
      .rd_value  (rd_value),
      .rd_valid  (rd_valid)
   );

   // Watchdog slave: writes other than LOCK only land while unlocked
   logic [31:0] s_load = 32'h0, s_value = 32'h0, s_lock = 32'h0;
   logic [1:0]  s_ctrl = 2'b00;
   logic        dogint = 1'b0;
   wire         s_open = (s_lock == KEY);

   always @(posedge clk) begin
      if (s_ctrl[0]) begin
         if (s_value == 32'h0) begin
            s_value <= s_load;
            dogint  <= 1'b1;
         end else begin
            s_value <= s_value - 32'd1;
         end
      end
      if (psel && penable && pwrite) begin
         case (paddr)
            10'h300: s_lock <= pwdata;
            10'h000: if (s_open) begin s_load <= pwdata; s_value <= pwdata; end
            10'h002: if (s_open) s_ctrl <= pwdata[1:0];
            10'h003: if (s_open) begin dogint <= 1'b0; s_value <= s_load; end
            default: ;
         endcase
      end
   end

   assign prdata = (psel && !pwrite && paddr == 10'h001) ? s_value : 32'h0;

   function automatic logic [63:0] tr(input logic [9:0] a, input logic w, input logic [31:0] d);
      return {21'b0, a, w, d};
   endfunction

   logic [63:0] log_q[$];
   int          proto_err = 0;
   logic        p_psel = 1'b0, p_pen = 1'b0, p_wr = 1'b0;
   logic [9:0]  p_addr = 10'h0;
   logic [31:0] p_wd = 32'h0;

   always @(posedge clk) begin
      if (penable && !(psel && p_psel && !p_pen)) proto_err++;
      if (penable && (paddr !== p_addr || pwrite !== p_wr || pwdata !== p_wd)) proto_err++;
      if (psel && penable && !pwrite && $isunknown(prdata)) proto_err++;
      if (psel && penable) log_q.push_back(tr(paddr, pwrite, pwrite ? pwdata : prdata));
      p_psel <= psel;
      p_pen  <= penable;
      p_wr   <= pwrite;
      p_addr <= paddr;
      p_wd   <= pwdata;
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input string tag, input int idx, input logic [63:0] exp);
      logic [63:0] obs;
      obs = (idx < log_q.size()) ? log_q[idx] : {64{1'b1}};
      chk(tag, obs, exp);
   endtask

   // Called in the first SETUP cycle; returns in the done cycle
   task automatic run_seq(input string tag, input int exp_cycles);
      int n, b;
      n = 0;
      b = 0;
      while (!done && n < 40) begin
         if (busy) b++;
         tick();
         n++;
      end
      chk({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
      chk({tag, "_busy"}, 64'(b), 64'(exp_cycles));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1;
      cfg_req = 1'b0; kick_req = 1'b0; stop_req = 1'b0; rd_req = 1'b0;
      cfg_load = 32'h0; cfg_inten = 1'b0; cfg_resen = 1'b0;
      repeat (3) tick();
      chk("rst_apb", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(0));
      chk("rst_status", 64'({busy, done, rd_valid, rd_value}), 64'(0));
      reset = 1'b0;
      tick();

      // CFG: load 0x100, inten+resen
      log_q.delete();
      cfg_load = 32'h0000_0100; cfg_inten = 1'b1; cfg_resen = 1'b1; cfg_req = 1'b1;
      tick();
      cfg_req = 1'b0; cfg_load = 32'hDEAD_BEEF;
      chk("cfg_setup0", 64'({psel, penable, pwrite, paddr, pwdata}), 64'({1'b1, 1'b0, 1'b1, 10'h300, KEY}));
      run_seq("cfg", 8);
      chk("cfg_nlog", 64'(log_q.size()), 64'(4));
      chk_log("cfg_t0", 0, tr(10'h300, 1'b1, KEY));
      chk_log("cfg_t1", 1, tr(10'h000, 1'b1, 32'h100));
      chk_log("cfg_t2", 2, tr(10'h002, 1'b1, 32'h3));
      chk_log("cfg_t3", 3, tr(10'h300, 1'b1, 32'h0));
      tick();
      chk("cfg_after", 64'({busy, done, psel}), 64'(0));
      chk("wd_ctrl", 64'(s_ctrl), 64'(3));

      // KICK once the interrupt is up
      n = 0;
      while (!dogint && n < 600) begin tick(); n++; end
      chk("dogint_set", 64'(dogint), 64'(1));
      log_q.delete();
      kick_req = 1'b1;
      tick();
      kick_req = 1'b0;
      run_seq("kick", 6);
      chk("kick_nlog", 64'(log_q.size()), 64'(3));
      chk_log("kick_t1", 1, tr(10'h003, 1'b1, 32'h1));
      chk_log("kick_t2", 2, tr(10'h300, 1'b1, 32'h0));
      chk("dogint_clr", 64'(dogint), 64'(0));

      // RD
      tick();
      log_q.delete();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("rd_setup", 64'({psel, penable, pwrite, paddr}), 64'({1'b1, 1'b0, 1'b0, 10'h001}));
      run_seq("rd", 2);
      chk("rd_valid", 64'(rd_valid), 64'(1));
      chk("rd_nlog", 64'(log_q.size()), 64'(1));
      chk("rd_addr", 64'(log_q[0][63:32]), 64'({10'h001, 1'b0}));
      chk("rd_value", 64'(rd_value), 64'(log_q[0][31:0]));
      chk("rd_range", 64'(rd_value <= 32'h100), 64'(1));
      tick();
      chk("rd_valid_pulse", 64'({rd_valid, done}), 64'(0));

      // Request on the done cycle is latched and starts right after
      log_q.delete();
      kick_req = 1'b1;
      tick();
      kick_req = 1'b0;
      run_seq("kick2", 6);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("rd2_setup", 64'({psel, pwrite, paddr}), 64'({1'b1, 1'b0, 10'h001}));
      run_seq("rd2", 2);
      chk("rd2_valid", 64'(rd_valid), 64'(1));
      chk("rd2_nlog", 64'(log_q.size()), 64'(4));

      // stop+kick+cfg together: STOP, then CFG, kick dropped
      tick();
      log_q.delete();
      cfg_load = 32'h40; cfg_inten = 1'b1; cfg_resen = 1'b0;
      stop_req = 1'b1; kick_req = 1'b1; cfg_req = 1'b1;
      tick();
      stop_req = 1'b0; kick_req = 1'b0; cfg_req = 1'b0;
      run_seq("stop", 6);
      chk_log("stop_t1", 1, tr(10'h002, 1'b1, 32'h0));
      tick();
      chk("cfg2_start", 64'({psel, penable, paddr}), 64'({1'b1, 1'b0, 10'h300}));
      run_seq("cfg2", 8);
      n = 0;
      repeat (12) begin tick(); if (done) n++; end
      chk("no_kick_done", 64'(n), 64'(0));
      chk("multi_nlog", 64'(log_q.size()), 64'(7));
      chk_log("cfg2_load", 4, tr(10'h000, 1'b1, 32'h40));
      chk_log("cfg2_ctrl", 5, tr(10'h002, 1'b1, 32'h1));

      // Reset during the LOAD transfer's ACCESS
      log_q.delete();
      cfg_load = 32'h80; cfg_inten = 1'b1; cfg_resen = 1'b1; cfg_req = 1'b1;
      tick();
      cfg_req = 1'b0;
      repeat (3) tick();
      chk("mid_access", 64'({psel, penable, paddr}), 64'({1'b1, 1'b1, 10'h000}));
      reset = 1'b1;
      tick();
      chk("mid_rst_apb", 64'({psel, penable, busy, done}), 64'(0));
      chk("mid_rst_rdval", 64'(rd_value), 64'(0));
      reset = 1'b0;
      repeat (5) tick();
      chk("mid_rst_nlog", 64'(log_q.size()), 64'(2));
      chk("mid_rst_idle", 64'(busy), 64'(0));
      log_q.delete();
      cfg_req = 1'b1;
      tick();
      cfg_req = 1'b0;
      run_seq("cfg3", 8);
      chk("cfg3_nlog", 64'(log_q.size()), 64'(4));
      chk_log("cfg3_load", 1, tr(10'h000, 1'b1, 32'h80));
      chk_log("cfg3_ctrl", 2, tr(10'h002, 1'b1, 32'h3));

      tick();
      chk("protocol", 64'(proto_err), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
